// File: rtl/ex_pkg.sv
// Shared encodings for the execute-stage ALU: op classes, funct3 codes, FSM states.
package ex_pkg;

   typedef enum logic [2:0] {
      OP_LDST   = 3'd0,
      OP_BRANCH = 3'd1,
      OP_RTYPE  = 3'd2,
      OP_ITYPE  = 3'd3,
      OP_LUI    = 3'd4,
      OP_AUIPC  = 3'd5,
      OP_JAL    = 3'd6,
      OP_JALR   = 3'd7
   } alu_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

endpackage

// File: rtl/ex_shifter.sv
// Barrel or iterative shifter; done/result are combinational so the final step
// lands in the caller's output register on the same edge it completes.
module ex_shifter #(
   parameter  int XLEN       = 32,
   parameter  int SHIFT_STEP = 1,
   localparam int SHAMT_W    = $clog2(XLEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               dir,
   input  logic               arith,
   input  logic [XLEN-1:0]    value,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               done,
   output logic [XLEN-1:0]    result
);

   // dir=1 shifts left; arith only matters for right shifts
   function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                                input logic [SHAMT_W-1:0] n,
                                                input logic left, input logic ar);
      if (left)    return v << n;
      else if (ar) return $signed(v) >>> n;
      else         return v >> n;
   endfunction

   generate
      if (SHIFT_STEP >= XLEN) begin : g_single
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst_n};
         assign done      = start;
         assign result    = shift_by(value, shamt, dir, arith);
      end else begin : g_iter
         localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);
         logic               busy, dir_q, arith_q;
         logic [SHAMT_W-1:0] rem, step;
         logic [XLEN-1:0]    val, stepped;

         assign step    = (rem > STEP) ? STEP : rem;
         assign stepped = shift_by(val, step, dir_q, arith_q);
         assign done    = (start && shamt == '0) || (busy && rem <= STEP);
         assign result  = busy ? stepped : value;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               busy    <= 1'b0;
               dir_q   <= 1'b0;
               arith_q <= 1'b0;
               rem     <= '0;
               val     <= '0;
            end else if (start && shamt != '0) begin
               busy    <= 1'b1;
               dir_q   <= dir;
               arith_q <= arith;
               rem     <= shamt;
               val     <= value;
            end else if (busy) begin
               val <= stepped;
               rem <= rem - step;
               if (rem <= STEP) busy <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with branch resolution, iterative shifts and post-redirect
// squashing of wrong-path ops until the op tagged with the target PC arrives.
module ex_alu_unit
   import ex_pkg::*;
#(
   parameter  int XLEN       = 32,
   parameter  int SHIFT_STEP = 1,
   parameter  int IMM_SHIFT  = 1,
   localparam int SHAMT_W    = $clog2(XLEN)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_ALUop,
   input  logic [2:0]      i_func3,
   input  logic            i_func7,
   input  logic [XLEN-1:0] i_A,
   input  logic [XLEN-1:0] i_B,
   input  logic [XLEN-1:0] i_Imm_SignExt,
   input  logic [XLEN-1:0] i_NPC,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_ALUOutput,
   output logic            o_branch,
   output logic [XLEN-1:0] o_target,
   output logic            o_redirect,
   output logic            o_busy
);

   alu_op_e            op;
   state_e             state;
   logic               squash, accept, drop, is_shift, taken;
   logic               sh_start, sh_done;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    sq_tgt, opb, jalr_sum, tgt, tgt_out, alu_res, sh_result;

   assign op       = alu_op_e'(i_ALUop);
   assign o_ready  = (state == ST_IDLE) && (!o_valid || i_ready);
   assign o_busy   = (state != ST_IDLE) || squash;
   assign accept   = i_valid && o_ready;
   // wrong-path ops are swallowed without disturbing the handshake
   assign drop     = squash && (i_NPC != sq_tgt);
   assign opb      = (op == OP_RTYPE) ? i_B : i_Imm_SignExt;
   assign shamt    = opb[SHAMT_W-1:0];
   assign is_shift = (op == OP_RTYPE || op == OP_ITYPE) &&
                     (i_func3 == F3_SLL || i_func3 == F3_SR);
   assign sh_start = accept && !drop && is_shift;
   assign jalr_sum = i_A + i_Imm_SignExt;
   assign tgt      = (op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                     : i_NPC + (i_Imm_SignExt << IMM_SHIFT);
   assign tgt_out  = (op == OP_BRANCH || op == OP_AUIPC || op == OP_JAL || op == OP_JALR)
                     ? tgt : '0;

   ex_shifter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shifter (
      .clk(i_clk), .rst_n(i_reset), .start(sh_start),
      .dir(i_func3 == F3_SLL), .arith(i_func3 == F3_SR && i_func7),
      .value(i_A), .shamt(shamt), .done(sh_done), .result(sh_result)
   );

   always_comb begin
      taken = 1'b0;
      case (op)
         OP_BRANCH: begin
            case (i_func3)
               F3_BEQ:  taken = (i_A == i_B);
               F3_BNE:  taken = (i_A != i_B);
               F3_BLT:  taken = ($signed(i_A) <  $signed(i_B));
               F3_BGE:  taken = ($signed(i_A) >= $signed(i_B));
               F3_BLTU: taken = (i_A <  i_B);
               F3_BGEU: taken = (i_A >= i_B);
               default: taken = 1'b0;
            endcase
         end
         OP_JAL, OP_JALR: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = tgt;
      case (op)
         OP_LDST: alu_res = i_A + i_Imm_SignExt;
         OP_RTYPE, OP_ITYPE: begin
            case (i_func3)
               F3_ADD:  alu_res = (op == OP_RTYPE && i_func7) ? i_A - opb : i_A + opb;
               F3_SLT:  alu_res = XLEN'($signed(i_A) < $signed(opb));
               F3_SLTU: alu_res = XLEN'(i_A < opb);
               F3_XOR:  alu_res = i_A ^ opb;
               F3_OR:   alu_res = i_A | opb;
               F3_AND:  alu_res = i_A & opb;
               default: alu_res = sh_result;
            endcase
         end
         OP_LUI:  alu_res = i_Imm_SignExt;
         default: alu_res = tgt;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= ST_IDLE;
         squash      <= 1'b0;
         sq_tgt      <= '0;
         o_valid     <= 1'b0;
         o_ALUOutput <= '0;
         o_branch    <= 1'b0;
         o_target    <= '0;
         o_redirect  <= 1'b0;
      end else begin
         o_redirect <= 1'b0;
         if (o_valid && i_ready) o_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept && !drop) begin
                  squash <= 1'b0;
                  if (is_shift && !sh_done) begin
                     state <= ST_SHIFT;
                  end else begin
                     o_valid     <= 1'b1;
                     o_ALUOutput <= alu_res;
                     o_branch    <= taken;
                     o_target    <= tgt_out;
                     // a taken transfer re-arms squashing toward its own target
                     if (taken) begin
                        o_redirect <= 1'b1;
                        squash     <= 1'b1;
                        sq_tgt     <= tgt;
                     end
                  end
               end
            end
            ST_SHIFT: begin
               if (sh_done) begin
                  o_valid     <= 1'b1;
                  o_ALUOutput <= sh_result;
                  o_branch    <= 1'b0;
                  o_target    <= '0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
